// File: rtl/centroid_calc_if.sv
// Purpose: video-in / centroid-out bundle for centroid_calc.
// Ports: de, vsync, mask_in (video side); x_center, y_center, centroid_valid,
//        obj_found, obj_count, busy (result side). slave = block, master = source/sink.
interface centroid_calc_if;
  logic        de;
  logic        vsync;
  logic        mask_in;
  logic [10:0] x_center;
  logic [10:0] y_center;
  logic        centroid_valid;
  logic        obj_found;
  logic [19:0] obj_count;
  logic        busy;

  modport slave (
    input  de, vsync, mask_in,
    output x_center, y_center, centroid_valid, obj_found, obj_count, busy
  );

  modport master (
    output de, vsync, mask_in,
    input  x_center, y_center, centroid_valid, obj_found, obj_count, busy
  );
endinterface

// File: rtl/centroid_calc.sv
// Purpose: per-frame centroid (m10/m00, m01/m00) of a binary mask from a de/vsync stream.
// Latency: result published 62 cycles after the vsync rise edge; held until the next publication.
// Backpressure: none; streaming input, a new vsync rise aborts any division in progress.
// Ports: clk, rst_n (async, active low), bus (centroid_calc_if.slave: de, vsync, mask_in in;
//        x_center, y_center, centroid_valid, obj_found, obj_count, busy out).
// Option: define CENTROID_ROUND_EN for round-half-up quotients (adds m00>>1 to each dividend).
module centroid_calc #(
  parameter int IMG_W      = 1280,
  parameter int IMG_H      = 720,
  parameter int MIN_PIXELS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  centroid_calc_if.slave  bus
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [4:0] LAST_X = 5'd30;  // DIV_X: cnt 0 loads, cnt 1..30 are the 30 steps
  localparam logic [4:0] LAST_Y = 5'd29;  // DIV_Y: cnt 0..29 are the 30 steps

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

  state_t state_q, state_d;

  logic          vsync_d;
  logic          rise;
  logic [XW-1:0] x_pos;
  logic [YW-1:0] y_pos;
  logic [19:0]   m00;
  logic [29:0]   m10, m01;
  logic [19:0]   snap_m00;
  logic [29:0]   snap_m10, snap_m01;
  logic [4:0]    cnt;

  logic          load_x, step, cap_x, cap_y, publish;

  logic [19:0]   divisor;
  logic [29:0]   rnd, dvd_x, dvd_y;
  logic [19:0]   rem, rem_n;
  logic [29:0]   qd, qd_n, q_x;
  logic [20:0]   trial;
  logic          ge;

  logic [10:0]   x_center_q, y_center_q;
  logic          valid_q, found_q;
  logic [19:0]   count_q;

  assign rise = bus.vsync & ~vsync_d;

  // Position counters and moment accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      x_pos   <= '0;
      y_pos   <= '0;
      m00     <= '0;
      m10     <= '0;
      m01     <= '0;
    end else begin
      vsync_d <= bus.vsync;
      if (bus.vsync) begin
        x_pos <= '0;
        y_pos <= '0;
        m00   <= '0;
        m10   <= '0;
        m01   <= '0;
      end else if (bus.de) begin
        if (bus.mask_in) begin
          m00 <= m00 + 20'd1;
          m10 <= m10 + 30'(x_pos);
          m01 <= m01 + 30'(y_pos);
        end
        if (x_pos == XW'(IMG_W - 1)) begin
          x_pos <= '0;
          y_pos <= (y_pos == YW'(IMG_H - 1)) ? '0 : y_pos + 1'b1;
        end else begin
          x_pos <= x_pos + 1'b1;
        end
      end
    end
  end

  // Snapshot of the finished frame; live accumulators clear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_m00 <= '0;
      snap_m10 <= '0;
      snap_m01 <= '0;
    end else if (rise) begin
      snap_m00 <= m00;
      snap_m10 <= m10;
      snap_m01 <= m01;
    end
  end

  // FSM state register and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (rise || state_d != state_q) cnt <= '0;
      else if (state_q != IDLE)       cnt <= cnt + 5'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    load_x  = 1'b0;
    step    = 1'b0;
    cap_x   = 1'b0;
    cap_y   = 1'b0;
    publish = 1'b0;
    case (state_q)
      IDLE: ;
      DIV_X: begin
        if (cnt == 5'd0) begin
          load_x = 1'b1;
        end else begin
          step = 1'b1;
          if (cnt == LAST_X) begin
            cap_x   = 1'b1;
            state_d = DIV_Y;
          end
        end
      end
      DIV_Y: begin
        step = 1'b1;
        if (cnt == LAST_Y) begin
          cap_y   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        publish = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new frame end always wins: restart on the fresh snapshot, drop the old result.
    if (rise) begin
      state_d = DIV_X;
      load_x  = 1'b0;
      step    = 1'b0;
      cap_x   = 1'b0;
      cap_y   = 1'b0;
      publish = 1'b0;
    end
  end

`ifdef CENTROID_ROUND_EN
  assign rnd = 30'(snap_m00 >> 1);
`else
  assign rnd = '0;
`endif

  assign divisor = (snap_m00 == 20'd0) ? 20'd1 : snap_m00;
  assign dvd_x   = snap_m10 + rnd;
  assign dvd_y   = snap_m01 + rnd;

  // Restoring divider step: qd shifts the dividend out at the top and quotient bits in at the bottom.
  assign trial = {rem, qd[29]};
  assign ge    = (trial >= {1'b0, divisor});
  assign rem_n = ge ? 20'(trial - {1'b0, divisor}) : trial[19:0];
  assign qd_n  = {qd[28:0], ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      qd  <= '0;
      q_x <= '0;
    end else if (load_x) begin
      rem <= '0;
      qd  <= dvd_x;
    end else if (cap_x) begin
      q_x <= qd_n;
      rem <= '0;
      qd  <= dvd_y;
    end else if (step) begin
      rem <= rem_n;
      qd  <= qd_n;  // after cap_y, qd holds the y quotient during DONE
    end
  end

  function automatic logic [10:0] sat11(input logic [29:0] q);
    return (q[29:11] != '0) ? 11'h7FF : q[10:0];
  endfunction

  // Published outputs only change in DONE, so they never move mid-division.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_center_q <= '0;
      y_center_q <= '0;
      valid_q    <= 1'b0;
      found_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      valid_q <= publish;
      if (publish) begin
        count_q <= snap_m00;
        if (snap_m00 >= 20'(MIN_PIXELS)) begin
          x_center_q <= sat11(q_x);
          y_center_q <= sat11(qd);
          found_q    <= 1'b1;
        end else begin
          found_q    <= 1'b0;
        end
      end
    end
  end

  assign bus.x_center       = x_center_q;
  assign bus.y_center       = y_center_q;
  assign bus.centroid_valid = valid_q;
  assign bus.obj_found      = found_q;
  assign bus.obj_count      = count_q;
  assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_centroid_calc.sv
// Bench for centroid_calc on a 128x64 image: directed frames, expected results queued at
// the vsync rise, checked by an independent monitor when centroid_valid pulses.
module tb_centroid_calc;

  localparam int W = 128;
  localparam int H = 64;

`ifdef CENTROID_ROUND_EN
  localparam int BLK_X = 11, BLK_Y = 21, FULL_X = 64, FULL_Y = 32, PAIR_X = 4;
`else
  localparam int BLK_X = 10, BLK_Y = 20, FULL_X = 63, FULL_Y = 31, PAIR_X = 3;
`endif

  typedef struct {
    int x;
    int y;
    int found;
    int cnt;
    int vcyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   errors = 0;
  exp_t exp_q[$];

  centroid_calc_if bus();

  centroid_calc #(.IMG_W(W), .IMG_H(H), .MIN_PIXELS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic bit mask_at(input int kind, input int x, input int y);
    case (kind)
      1:       return (x == 100 && y == 50);
      2:       return (x >= 10 && x <= 11 && y >= 20 && y <= 21);
      3:       return 1'b1;
      4:       return ((x == 3 || x == 4) && y == 0);
      default: return 1'b0;
    endcase
  endfunction

  // Drive npix pixels of pattern 'kind', then raise vsync; returns just after the rise edge.
  task automatic frame(input int kind, input int npix, input bit push,
                       input int ex, input int ey, input int ef, input int ec);
    exp_t e;
    for (int i = 0; i < npix; i++) begin
      @(negedge clk);
      bus.vsync   = 1'b0;
      bus.de      = 1'b1;
      bus.mask_in = mask_at(kind, i % W, (i / W) % H);
    end
    @(negedge clk);
    bus.de      = 1'b0;
    bus.mask_in = 1'b0;
    bus.vsync   = 1'b1;
    if (push) begin
      e.x = ex; e.y = ey; e.found = ef; e.cnt = ec; e.vcyc = cyc + 1 + 62;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check("pending_results", exp_q.size(), 0);
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.centroid_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_pulse: valid at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.vcyc);
        check("x_center", int'(bus.x_center), e.x);
        check("y_center", int'(bus.y_center), e.y);
        check("obj_found", int'(bus.obj_found), e.found);
        check("obj_count", int'(bus.obj_count), e.cnt);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.de = 1'b0;
    bus.vsync = 1'b0;
    bus.mask_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_x", int'(bus.x_center), 0);
    check("rst_y", int'(bus.y_center), 0);
    check("rst_valid", int'(bus.centroid_valid), 0);
    check("rst_found", int'(bus.obj_found), 0);
    check("rst_count", int'(bus.obj_count), 0);
    check("rst_busy", int'(bus.busy), 0);

    // Single pixel at (100,50)
    frame(1, 50 * W + 101, 1'b1, 100, 50, 1, 1);
    @(negedge clk);
    check("busy_after_rise", int'(bus.busy), 1);
    wait_drain();

    // 2x2 block
    frame(2, 21 * W + 12, 1'b1, BLK_X, BLK_Y, 1, 4);
    wait_drain();

    // Full frame
    frame(3, W * H, 1'b1, FULL_X, FULL_Y, 1, W * H);
    wait_drain();

    // Empty frame: position holds, found drops, pulse still issued
    frame(0, 100, 1'b1, FULL_X, FULL_Y, 0, 0);
    wait_drain();
    @(negedge clk);
    check("busy_idle", int'(bus.busy), 0);

    // Abort: second rise 10 cycles into DIV_X; only the second frame reports
    frame(1, 50 * W + 101, 1'b0, 0, 0, 0, 0);
    frame(4, 9, 1'b1, PAIR_X, 0, 1, 2);
    wait_drain();

    // Reset during DIV_Y
    frame(1, 50 * W + 101, 1'b0, 0, 0, 0, 0);
    repeat (45) @(negedge clk);
    check("busy_in_div_y", int'(bus.busy), 1);
    rst_n = 1'b0;
    bus.vsync = 1'b0;
    @(negedge clk);
    check("mid_rst_x", int'(bus.x_center), 0);
    check("mid_rst_y", int'(bus.y_center), 0);
    check("mid_rst_found", int'(bus.obj_found), 0);
    check("mid_rst_count", int'(bus.obj_count), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("post_rst_busy", int'(bus.busy), 0);

    // Next frame after reset computes normally
    frame(2, 21 * W + 12, 1'b1, BLK_X, BLK_Y, 1, 4);
    wait_drain();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
